// File: rtl/sha_result_check_pkg.sv
// Shared widths and endian helpers for the SHA result-checking slice.
package sha_result_check_pkg;

  localparam int WORD_S  = 32;
  localparam int HASH_S  = 256;
  localparam int NONCE_S = WORD_S;
  localparam int HALF_S  = HASH_S / 2;

  // Reverses byte order across the whole hash: result[7:0] = d[255:248].
  function automatic logic [HASH_S-1:0] byte_reverse(input logic [HASH_S-1:0] d);
    logic [HASH_S-1:0] r;
    r = '0;
    for (int i = 0; i < HASH_S / 8; i++) begin
      r[8*i +: 8] = d[HASH_S-1-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha_result_check_result_fifo.sv
// Synchronous FIFO for winning nonces: full/empty flags, simultaneous
// push/pop (a push into a full FIFO succeeds if the head leaves that cycle),
// and a synchronous clear that empties it.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             accept_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign accept_o = do_push;
  assign dout_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; zeroed on reset so the head reads 0 until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clear_i && do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/sha_result_check.sv
// Checks each valid SHA-256 result against a programmable target, queues
// winning nonces for a valid/ready consumer and keeps status counters.
module sha_result_check
  import sha_result_check_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit BYTE_SWAP  = 1'b1,
  parameter int CNT_W      = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [HASH_S-1:0]  H,
  input  logic [NONCE_S-1:0] nonce,
  input  logic [HASH_S-1:0]  target,
  input  logic               target_load,
  input  logic               clear,
  output logic               out_valid,
  output logic [NONCE_S-1:0] out_nonce,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   hash_count,
  output logic [CNT_W-1:0]   hit_count,
  output logic               overflow
);

  logic [HASH_S-1:0]  target_q, target_d;
  logic [HASH_S-1:0]  cmp_val;
  logic               s1_valid_q, s1_valid_d;
  logic [NONCE_S-1:0] s1_nonce_q, s1_nonce_d;
  logic               hi_lt_q, hi_lt_d;
  logic               hi_eq_q, hi_eq_d;
  logic               lo_lt_q, lo_lt_d;
  logic [CNT_W-1:0]   hash_count_q, hash_count_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic               overflow_q, overflow_d;
  logic               hit, push, pop, accept, fifo_empty, fifo_full;

  assign cmp_val = BYTE_SWAP ? byte_reverse(H) : H;

  // Stage-1 next state: split the 256-bit compare into two 128-bit halves.
  always_comb begin
    target_d   = target_load ? target : target_q;
    s1_valid_d = en && !clear;
    s1_nonce_d = s1_nonce_q;
    hi_lt_d    = hi_lt_q;
    hi_eq_d    = hi_eq_q;
    lo_lt_d    = lo_lt_q;
    if (en) begin
      s1_nonce_d = nonce;
      hi_lt_d    = cmp_val[HASH_S-1:HALF_S] <  target_q[HASH_S-1:HALF_S];
      hi_eq_d    = cmp_val[HASH_S-1:HALF_S] == target_q[HASH_S-1:HALF_S];
      lo_lt_d    = cmp_val[HALF_S-1:0]      <  target_q[HALF_S-1:0];
    end
  end

  // Stage 2 resolves the halves into a hit; clear discards it.
  assign hit  = s1_valid_q && (hi_lt_q || (hi_eq_q && lo_lt_q));
  assign push = hit && !clear;
  assign pop  = out_valid && out_ready;

  // Status counters and sticky overflow next state.
  always_comb begin
    hash_count_d = hash_count_q;
    hit_count_d  = hit_count_q;
    overflow_d   = overflow_q;
    if (clear) begin
      hash_count_d = '0;
      hit_count_d  = '0;
      overflow_d   = 1'b0;
    end else begin
      if (en)              hash_count_d = hash_count_q + CNT_W'(1);
      if (hit)             hit_count_d  = hit_count_q + CNT_W'(1);
      if (push && !accept) overflow_d   = 1'b1;
    end
  end

  // All datapath and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_nonce_q   <= '0;
      hi_lt_q      <= 1'b0;
      hi_eq_q      <= 1'b0;
      lo_lt_q      <= 1'b0;
      hash_count_q <= '0;
      hit_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      target_q     <= target_d;
      s1_valid_q   <= s1_valid_d;
      s1_nonce_q   <= s1_nonce_d;
      hi_lt_q      <= hi_lt_d;
      hi_eq_q      <= hi_eq_d;
      lo_lt_q      <= lo_lt_d;
      hash_count_q <= hash_count_d;
      hit_count_q  <= hit_count_d;
      overflow_q   <= overflow_d;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_S)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    (s1_nonce_q),
    .dout_o   (out_nonce),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full),
    .accept_o (accept)
  );

  assign out_valid  = !fifo_empty;
  assign hash_count = hash_count_q;
  assign hit_count  = hit_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sha_result_check.sv
// Scoreboard bench for sha_result_check: predicted FIFO contents are queued
// when hashes are driven and compared as the consumer pops them.
module tb_sha_result_check;

  localparam int DEPTH = 4;

  logic         clk;
  logic         reset, en, target_load, clear, out_ready;
  logic         out_valid, overflow;
  logic [255:0] H, target;
  logic [31:0]  nonce, out_nonce;
  logic [47:0]  hash_count, hit_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  expQ[$];
  logic [255:0] mdlTarget = '0;
  logic         pendValid = 1'b0;
  logic [31:0]  pendNonce = '0;
  logic [47:0]  mdlHashes = '0;
  logic [47:0]  mdlHits   = '0;
  logic         mdlOverflow = 1'b0;

  sha_result_check #(
    .FIFO_DEPTH (DEPTH),
    .BYTE_SWAP  (1'b1),
    .CNT_W      (48)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .H           (H),
    .nonce       (nonce),
    .target      (target),
    .target_load (target_load),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_nonce   (out_nonce),
    .out_ready   (out_ready),
    .hash_count  (hash_count),
    .hit_count   (hit_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [255:0] mdlSwap(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = h[8*i +: 8];
    return r;
  endfunction

  // Drives one cycle (called at a negedge) and advances the model in step.
  task automatic applyStimulus(input logic e, input logic [255:0] h, input logic [31:0] n,
                               input logic rdy, input logic clr, input logic ld,
                               input logic [255:0] tgt);
    logic [31:0] expHead;
    en = e; H = h; nonce = n; out_ready = rdy; clear = clr; target_load = ld; target = tgt;
    if (clr) begin
      expQ.delete();
      pendValid = 1'b0;
      mdlHashes = '0;
      mdlHits = '0;
      mdlOverflow = 1'b0;
    end else begin
      if (rdy && expQ.size() > 0) begin
        expHead = expQ.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_nonce !== expHead) begin
          failures++;
          $display("[TB] FAIL pop_head: out_valid=%b out_nonce=%h, expected out_valid=1 out_nonce=%h",
                   out_valid, out_nonce, expHead);
        end
      end
      if (pendValid) begin
        mdlHits++;
        if (expQ.size() < DEPTH) expQ.push_back(pendNonce);
        else mdlOverflow = 1'b1;
      end
      pendValid = e && (mdlSwap(h) < mdlTarget);
      pendNonce = n;
      if (e) mdlHashes++;
    end
    if (ld) mdlTarget = tgt;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input logic rdy);
    repeat (cycles) applyStimulus(1'b0, '0, '0, rdy, 1'b0, 1'b0, '0);
  endtask

  task automatic doReset();
    reset = 1'b0; en = 1'b0; H = '0; nonce = '0; target = '0;
    target_load = 1'b0; clear = 1'b0; out_ready = 1'b0;
    expQ.delete();
    pendValid = 1'b0; mdlHashes = '0; mdlHits = '0; mdlOverflow = 1'b0; mdlTarget = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (out_valid !== 1'b0 || out_nonce !== 32'h0 || hash_count !== 48'h0 ||
        hit_count !== 48'h0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: valid=%b nonce=%h hashes=%0d hits=%0d ovf=%b, expected all 0",
               out_valid, out_nonce, hash_count, hit_count, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, '0, 32'h11, 1'b0, 1'b0, 1'b0, '0);
    idle(1, 1'b0);
    checks++;
    if (hash_count !== mdlHashes) begin
      failures++;
      $display("[TB] FAIL idle_hash_count: got %0d expected %0d", hash_count, mdlHashes);
    end
    checks++;
    if (out_valid !== 1'b0 || hit_count !== mdlHits) begin
      failures++;
      $display("[TB] FAIL zero_target_no_hit: valid=%b hits=%0d expected valid=0 hits=%0d",
               out_valid, hit_count, mdlHits);
    end
  endtask

  task automatic test_byte_swap();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 256'd1 << 224);
    applyStimulus(1'b1, '0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_early: out_valid=%b expected 0 one cycle after en", out_valid);
    end
    idle(1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_nonce !== 32'hDEADBEEF || hit_count !== 48'd1) begin
      failures++;
      $display("[TB] FAIL latency_hit: valid=%b nonce=%h hits=%0d expected 1 deadbeef 1",
               out_valid, out_nonce, hit_count);
    end
    idle(1, 1'b1);
    applyStimulus(1'b1, 256'h01 << 248, 32'hA1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 256'h02, 32'hA2, 1'b0, 1'b0, 1'b0, '0);
    idle(2, 1'b0);
    checks++;
    if (hit_count !== mdlHits || out_valid !== (expQ.size() != 0)) begin
      failures++;
      $display("[TB] FAIL swap_order: hits=%0d valid=%b expected hits=%0d valid=%b",
               hit_count, out_valid, mdlHits, expQ.size() != 0);
    end
    idle(2, 1'b1);
  endtask

  task automatic test_boundary();
    logic [255:0] t;
    t = {128'h0000_0000_0000_0000_0000_0001_0000_0000, 128'h8000_0000_0000_0000_0000_0000_0000_0010};
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, t);
    applyStimulus(1'b1, mdlSwap({t[255:128], t[127:0] - 128'd1}), 32'hB1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, mdlSwap(t), 32'hB2, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, mdlSwap({t[255:128], t[127:0] + 128'd1}), 32'hB3, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, mdlSwap({t[255:128] - 128'd1, {128{1'b1}}}), 32'hB4, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, mdlSwap({t[255:128] + 128'd1, 128'd0}), 32'hB5, 1'b0, 1'b0, 1'b0, '0);
    idle(2, 1'b0);
    checks++;
    if (hit_count !== mdlHits) begin
      failures++;
      $display("[TB] FAIL boundary_hits: got %0d expected %0d", hit_count, mdlHits);
    end
    checks++;
    if (hash_count !== mdlHashes) begin
      failures++;
      $display("[TB] FAIL boundary_hashes: got %0d expected %0d", hash_count, mdlHashes);
    end
    idle(3, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boundary_drained: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, {256{1'b1}});
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, '0, i[31:0], 1'b0, 1'b0, 1'b0, '0);
    idle(2, 1'b0);
    checks++;
    if (overflow !== mdlOverflow || hit_count !== mdlHits) begin
      failures++;
      $display("[TB] FAIL overflow_set: ovf=%b hits=%0d expected ovf=%b hits=%0d",
               overflow, hit_count, mdlOverflow, mdlHits);
    end
    idle(4, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_drain: valid=%b ovf=%b expected valid=0 ovf=1", out_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 5; i <= 8; i++) applyStimulus(1'b1, '0, i[31:0], 1'b0, 1'b0, 1'b0, '0);
    idle(2, 1'b0);
    applyStimulus(1'b1, '0, 32'd9, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle(1, 1'b0);
    checks++;
    if (overflow !== mdlOverflow || hit_count !== mdlHits) begin
      failures++;
      $display("[TB] FAIL full_pop_push: ovf=%b hits=%0d expected ovf=%b hits=%0d",
               overflow, hit_count, mdlOverflow, mdlHits);
    end
    idle(4, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_pop_drained: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_clear_load();
    applyStimulus(1'b1, '0, 32'hC1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, '0, 32'hC2, 1'b0, 1'b1, 1'b0, '0);
    idle(2, 1'b0);
    checks++;
    if (hash_count !== mdlHashes || hit_count !== mdlHits || out_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_with_en: hashes=%0d hits=%0d valid=%b ovf=%b expected %0d %0d 0 0",
               hash_count, hit_count, out_valid, overflow, mdlHashes, mdlHits);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 256'd1 << 200);
    applyStimulus(1'b1, mdlSwap(256'd1 << 150), 32'hD1, 1'b0, 1'b0, 1'b1, 256'd1 << 100);
    applyStimulus(1'b1, mdlSwap(256'd1 << 150), 32'hD2, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, mdlSwap(256'd1 << 210), 32'hD3, 1'b0, 1'b0, 1'b1, 256'd1 << 220);
    applyStimulus(1'b1, mdlSwap(256'd1 << 210), 32'hD4, 1'b0, 1'b0, 1'b0, '0);
    idle(2, 1'b0);
    checks++;
    if (hit_count !== mdlHits || hash_count !== mdlHashes) begin
      failures++;
      $display("[TB] FAIL load_timing: hits=%0d hashes=%0d expected %0d %0d",
               hit_count, hash_count, mdlHits, mdlHashes);
    end
    idle(3, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_drained: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, '0, 32'hE1, 1'b0, 1'b0, 1'b0, '0);
    #2;
    doReset();
    checks++;
    if (out_valid !== 1'b0 || hash_count !== 48'h0 || hit_count !== 48'h0) begin
      failures++;
      $display("[TB] FAIL midstream_reset: valid=%b hashes=%0d hits=%0d expected 0 0 0",
               out_valid, hash_count, hit_count);
    end
    reset = 1'b1;
    @(negedge clk);
    idle(2, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || hit_count !== mdlHits) begin
      failures++;
      $display("[TB] FAIL midstream_lost: valid=%b hits=%0d expected 0 %0d", out_valid, hit_count, mdlHits);
    end
  endtask

  initial begin
    test_reset();
    test_byte_swap();
    test_boundary();
    test_overflow();
    test_back_to_back();
    test_clear_load();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_result_check.md
Name: sha_result_check

Overview:
- Downstream consumer of the pipelined SHA-256 block's output stream (H, nonce_out, en_next).
- Compares every valid 256-bit hash against a programmable target and queues winning nonces in a small FIFO, which a valid/ready consumer (AXI-lite glue / control FSM) drains.
- Also keeps hash and hit counters plus a sticky overflow flag for software status.

Parameters:
- FIFO_DEPTH, 4, winning-nonce FIFO entries; power of two, ≥2.
- BYTE_SWAP, 1, 1 = byte-reverse the full 256-bit H before comparing (Bitcoin little-endian convention); 0 = compare H as-is.
- CNT_W, 48, width of the hash and hit counters.

Ports:
- clk  in  1  single clock; all logic is in this domain.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  hash-valid strobe, driven by the SHA block's en_next.
- H  in  256  hash word; H[255:224] is word 0.
- nonce  in  32  nonce that accompanies H.
- target  in  256  target value; sampled only when target_load=1.
- target_load  in  1  latches target into the internal target register.
- clear  in  1  synchronous clear of the pipeline, FIFO, counters and flags.
- out_valid  out  1  FIFO not empty.
- out_nonce  out  32  FIFO head entry.
- out_ready  in  1  consumer accepts the head when out_valid & out_ready.
- hash_count  out  CNT_W  number of en pulses seen since reset/clear.
- hit_count  out  CNT_W  number of hits detected, including dropped ones.
- overflow  out  1  sticky; a hit was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous) sets all of these to 0: out_valid, out_nonce, hash_count, hit_count, overflow, the target register, the stage valids and the FIFO pointers.
  - Target 0 means nothing can hit.
- Compare value: when BYTE_SWAP=1, V = byte-reverse(H), i.e. V[7:0] = H[255:248]. Otherwise V = H.
- Hit condition: V < target_reg, unsigned 256-bit.
- Stage 1 (registered at the edge after en=1):
  - registers nonce and s1_valid;
  - registers hi_lt = V[255:128] < T[255:128];
  - registers hi_eq = V[255:128] == T[255:128];
  - registers lo_lt = V[127:0] < T[127:0].
- Stage 2 (combinational from stage 1): hit = s1_valid & (hi_lt | (hi_eq & lo_lt)).
  - A hit is written into the FIFO at the next edge.
- Latency: en at cycle N gives out_valid=1 at cycle N+2 if the FIFO was empty. Throughput is one hash per cycle, with no backpressure to the SHA pipe.
- hash_count increments on every cycle with en=1, at the stage-1 edge.
- hit_count increments on every hit. Both counters wrap modulo 2^CNT_W.
- FIFO:
  - A push is accepted when not full, or when a pop happens in the same cycle while full.
  - Otherwise the hit is dropped and overflow is set. overflow stays set until clear or reset.
  - A pop happens when out_valid & out_ready. Pop on empty is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - out_nonce shows the head from storage; it is stable while out_valid=1 and out_ready=0.
- target_load:
  - The new target takes effect for stage-1 compares starting the cycle after the load.
  - A load in the same cycle as en uses the old target for that hash.
- clear has priority over everything else. In that cycle:
  - FIFO is emptied, counters and overflow are zeroed, s1_valid is zeroed;
  - the en/hit of that cycle is discarded and not counted.
  - target_reg is retained.
- Reset asserted mid-stream: all in-flight hashes are lost; no partial state survives.

Decomposition:
- Add to sha.vh:
  - HASH_S (256) and NONCE_S (= WORD_S, 32);
  - a byte-reverse macro/function shared with other endian conversions.
- One natural sub-module: result_fifo, a parameterised synchronous FIFO with full/empty, simultaneous push/pop, and sync clear.
- The comparator stays inline.

Test Plan:
- Reset then idle:
  - all outputs 0;
  - en=1 with H=0 and target=0 → no hit; hash_count=1 two cycles later.
- BYTE_SWAP=1:
  - Setup: target=256'h0000_0001 << 224 (top 32 bits = 1). Drive H with its last byte (H[7:0]) = 8'h00 and the rest 0, nonce=32'hDEADBEEF.
  - Expected: out_valid rises exactly 2 cycles after en, with out_nonce=DEADBEEF and hit_count=1.
- Equal-high-half boundary:
  - Setup: V[255:128] == T[255:128].
  - V[127:0] = T[127:0] − 1 → hit.
  - V == T → no hit.
  - V[127:0] = T[127:0] + 1 → no hit.
- Overflow:
  - Setup: FIFO_DEPTH=4, out_ready=0, 6 consecutive hitting hashes with nonces 1..6.
  - Expected: FIFO holds 1..4, overflow=1, hit_count=6.
  - Then drain with out_ready=1 → pops yield 1, 2, 3, 4 in order.
- Full with simultaneous pop:
  - Setup: FIFO full, out_ready=1 in the same cycle a hit with nonce 9 arrives.
  - Expected: head pops, 9 is enqueued, overflow remains 0.
- Clear and target_load:
  - clear in the same cycle as en → hash_count=0 afterwards and the pending hit is lost.
  - target_load coincident with en → that hash is compared against the old target, and the next hash against the new one.
